instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/arm_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 36 +++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Field positions describe the raw instruction word layout seen by the decoder.
package arm_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 32;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry prefetch buffer holding a fetched word and its address.
// Only present when FETCH_PREFETCH_EN is defined; a flush empties it.
`ifdef FETCH_PREFETCH_EN
module fetch_buffer
    import arm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  waddr,
    output logic               full,
    output logic [INSTR_W-1:0] rdata,
    output logic [ADDR_W-1:0]  raddr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            rdata <= '0;
            raddr <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            rdata <= wdata;
            raddr <= waddr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory and presents them with decoded fields.
// FETCH_PREFETCH_EN keeps fetching while an instruction is held, using a one-entry buffer.
//   state | meaning
//   IDLE  | out of reset, no request yet
//   FETCH | request outstanding, nothing presented
//   HOLD  | instruction presented, waiting for the decoder
module instr_fetch_unit
    import arm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         cond,
    output logic [1:0]         op,
    output logic [5:0]         funct,
    output logic [3:0]         rn,
    output logic [3:0]         rd,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus8
);

    fetch_state_t       state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d, req_addr, req_addr_d, pc_out_q, pc_out_d;
    logic [ADDR_W-1:0]  target, pc_inc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d, discard, discard_d;
    logic               req, take, hs;

    assign target = branch_target & 32'hFFFF_FFFC;
    assign pc_inc = pc + 32'd4;
    assign hs     = valid_q & instr_ready;

`ifdef FETCH_PREFETCH_EN
    logic               buf_full, buf_push, buf_pop;
    logic [INSTR_W-1:0] buf_data;
    logic [ADDR_W-1:0]  buf_pc;

    fetch_buffer u_fetch_buffer (
        .clk   (clk),
        .reset (reset),
        .flush (branch_taken),
        .push  (buf_push),
        .pop   (buf_pop),
        .wdata (imem_rdata),
        .waddr (req_addr),
        .full  (buf_full),
        .rdata (buf_data),
        .raddr (buf_pc)
    );

    assign req = (state == FETCH) | ((state == HOLD) & ~buf_full);
`else
    assign req = (state == FETCH);
`endif

    assign take = req & imem_ack & ~discard & ~branch_taken;

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_addr_d = req_addr;
        discard_d  = discard;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
`ifdef FETCH_PREFETCH_EN
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
`endif
        if (branch_taken) begin
            // An unacked request runs to completion at its old address; its data is dropped.
            pc_d    = target;
            valid_d = 1'b0;
            state_d = FETCH;
            if (req && !imem_ack) begin
                discard_d = 1'b1;
            end else begin
                discard_d  = 1'b0;
                req_addr_d = target;
            end
        end else if (state == IDLE) begin
            state_d = FETCH;
        end else begin
            if (req && imem_ack && discard) begin
                discard_d  = 1'b0;
                req_addr_d = pc;
            end
            if (take) begin
                pc_d       = pc_inc;
                req_addr_d = pc_inc;
            end
            if (hs || !valid_q) begin
`ifdef FETCH_PREFETCH_EN
                if (buf_full) begin
                    instr_d  = buf_data;
                    pc_out_d = buf_pc;
                    valid_d  = 1'b1;
                    buf_pop  = 1'b1;
                end else
`endif
                if (take) begin
                    instr_d  = imem_rdata;
                    pc_out_d = req_addr;
                    valid_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
`ifdef FETCH_PREFETCH_EN
            end else if (take) begin
                buf_push = 1'b1;
`endif
            end
            state_d = valid_d ? HOLD : FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            req_addr <= req_addr_d;
            discard  <= discard_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = req_addr;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus8    = pc_out_q + 32'd8;
    assign cond        = instr_q[COND_HI:COND_LO];
    assign op          = instr_q[OP_HI:OP_LO];
    assign funct       = instr_q[FUNCT_HI:FUNCT_LO];
    assign rn          = instr_q[RN_HI:RN_LO];
    assign rd          = instr_q[RD_HI:RD_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model with random wait states feeds the DUT,
// and the expected stream of presented addresses is a sequential PC that restarts on branch or reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
    localparam int EXP_HS_PER_20 = 20;
`else
    localparam int EXP_HS_PER_20 = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int max_wait = 0;
    int fixed_wait = -1;
    bit stray_ack = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] ack_log[$];
    logic [31:0] next_push = '0;

    instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_ready   (instr_ready),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rn            (rn),
        .rd            (rd),
        .pc_out        (pc_out),
        .pc_plus8      (pc_plus8)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'hE281_1001;
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9671;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory model: random or fixed wait states, random acks while idle.
    int wait_left = 0;
    bit busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset || !imem_req) begin
            busy       = 1'b0;
            imem_ack   = stray_ack ? 1'($urandom % 2) : 1'b0;
            imem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
            end
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                ack_log.push_back(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end
    end

    // Monitor / scoreboard.
    bit          prev_pending = 1'b0;
    bit          prev_branch = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] mon_pc;
    logic [31:0] mon_word;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            next_push    = TB_RESET_PC;
            prev_pending = 1'b0;
            prev_branch  = 1'b0;
        end else begin
            if (prev_pending) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (prev_branch) check("valid_after_branch", 32'(instr_valid), 32'd0);
            if (instr_valid && instr_ready) begin
                mon_pc   = exp_q.pop_front();
                mon_word = mem_word(mon_pc);
                check("pc_out", pc_out, mon_pc);
                check("instr", instr, mon_word);
                check("cond", 32'(cond), 32'(mon_word[31:28]));
                check("op", 32'(op), 32'(mon_word[27:26]));
                check("funct", 32'(funct), 32'(mon_word[25:20]));
                check("rn", 32'(rn), 32'(mon_word[19:16]));
                check("rd", 32'(rd), 32'(mon_word[15:12]));
                check("pc_plus8", pc_plus8, mon_pc + 32'd8);
                if (mon_word == 32'hE281_1001) begin
                    check("e281_cond", 32'(cond), 32'hE);
                    check("e281_op", 32'(op), 32'h0);
                    check("e281_funct", 32'(funct), 32'h28);
                    check("e281_rn", 32'(rn), 32'h1);
                    check("e281_rd", 32'(rd), 32'h1);
                end
                hs_count++;
            end
            if (branch_taken) begin
                exp_q.delete();
                next_push = branch_target & 32'hFFFF_FFFC;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back(next_push);
                next_push = next_push + 32'd4;
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            prev_branch  = branch_taken;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          n0;
        int          h0;
        bit          found;
        logic [31:0] old_addr;
        logic [31:0] snap_instr;
        logic [31:0] snap_pc;

        // Reset state.
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, TB_RESET_PC);

        // Zero-wait memory, decoder always ready.
        step();
        stray_ack   = 1'b0;
        instr_ready = 1'b1;
        n0          = ack_log.size();
        reset       = 1'b0;
        c = 0;
        while (!instr_valid && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("first_valid_latency", 32'(c), 32'd2);
        repeat (6) @(negedge clk);
        h0 = hs_count;
        repeat (20) @(negedge clk);
        check("throughput", 32'(hs_count - h0), 32'(EXP_HS_PER_20));
        found = (ack_log.size() >= n0 + 3);
        check("seq_len", 32'(found), 32'd1);
        if (found) begin
            check("seq_addr0", ack_log[n0], 32'h0);
            check("seq_addr1", ack_log[n0 + 1], 32'h4);
            check("seq_addr2", ack_log[n0 + 2], 32'h8);
        end

        // Decoder stalls: presented instruction holds.
        step();
        instr_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = instr_valid;
        end
        check("stall_valid_timeout", 32'(found), 32'd1);
        snap_instr = instr;
        snap_pc    = pc_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, snap_instr);
            check("stall_pc", pc_out, snap_pc);
`ifndef FETCH_PREFETCH_EN
            check("stall_no_req", 32'(imem_req), 32'd0);
`endif
        end

        // Branch during a 3-wait request.
        step();
        instr_ready = 1'b1;
        fixed_wait  = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            found = imem_req && !imem_ack;
        end
        check("wait_req_timeout", 32'(found), 32'd1);
        old_addr = imem_addr;
        n0       = ack_log.size();
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) check("no_stale_valid", pc_out, 32'h0000_0100);
            found = (ack_log.size() >= n0 + 2);
        end
        check("redirect_timeout", 32'(found), 32'd1);
        if (found) begin
            check("dropped_ack_addr", ack_log[n0], old_addr);
            check("redirect_addr", ack_log[n0 + 1], 32'h0000_0100);
        end

        // PC wrap.
        step();
        fixed_wait    = -1;
        max_wait      = 0;
        n0            = ack_log.size();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            for (int k = n0; k + 1 < ack_log.size(); k++) begin
                if (ack_log[k] == 32'hFFFF_FFFC) begin
                    check("wrap_addr", ack_log[k + 1], 32'h0);
                    found = 1'b1;
                    break;
                end
            end
        end
        check("wrap_timeout", 32'(found), 32'd1);

        // Randomized traffic with branches, stalls, stray acks and mid-run resets.
        max_wait  = 3;
        stray_ack = 1'b1;
        h0        = hs_count;
        for (int i = 0; i < 800; i++) begin
            step();
            instr_ready = ($urandom % 4) != 0;
            if (i % 200 == 150) begin
                reset        = 1'b1;
                branch_taken = 1'b0;
            end else begin
                reset        = 1'b0;
                branch_taken = ($urandom % 16) == 0;
                if ($urandom % 4 == 0) branch_target = 32'hFFFF_FFF0 | ($urandom % 16);
                else branch_target = $urandom;
            end
        end
        step();
        reset        = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        repeat (20) step();
        check("random_progress", 32'(hs_count - h0 > 60), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
